// File: rtl/interp_wr_ctrl.sv
// Write-side sequencer for the 2x bilinear interpolation datapath: paces input pixels into
// two slots each and drives the shift/line-FIFO strobes. Optional macro: INTERP_OVF_DETECT_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | waiting for start, all strobes quiet
// RST_FIFO | afifo_rst pulse, then wait for both write-side reset busies
// FILL     | row 0: prime the shift FIFOs, no line-FIFO writes
// STREAM   | rows 1..IMG_HEIGHT-1: accept input, write line FIFOs from row 2
// FLUSH    | rows IMG_HEIGHT, IMG_HEIGHT+1: slots with no input
// DONE     | drain the strobe delay line, pulse frame_done
module interp_wr_ctrl #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIPE_LAT   = 2,
  parameter int RST_CYCLES = 4
) (
  input  logic sclk,
  input  logic rst,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  input  logic afifo0_full,
  input  logic afifo1_full,
  input  logic afifo0_wr_rst_busy,
  input  logic afifo1_wr_rst_busy,
  output logic sel0,
  output logic sfifo0_ce,
  output logic sfifo1_ce,
  output logic afifo0_wr_en,
  output logic afifo1_wr_en,
  output logic afifo_rst,
  output logic busy,
  output logic frame_done,
  output logic ovf_err
);

  localparam int SLOTS  = 2 * IMG_WIDTH;
  localparam int COL_W  = $clog2(SLOTS);
  localparam int ROW_W  = $clog2(IMG_HEIGHT + 2);
  localparam int RCNT_W = $clog2(RST_CYCLES + 1);
  localparam int DCNT_W = $clog2(PIPE_LAT + 1);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(SLOTS - 1);
  localparam logic [ROW_W-1:0] ROW_PRE   = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [ROW_W-1:0] ROW_FLUSH = ROW_W'(IMG_HEIGHT);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_HEIGHT + 1);
  localparam logic [ROW_W-1:0] ROW_WR    = ROW_W'(2);

  typedef enum logic [2:0] {IDLE, RST_FIFO, FILL, STREAM, FLUSH, DONE} state_t;

  state_t            state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [RCNT_W-1:0] rst_cnt;
  logic [DCNT_W-1:0] drain_cnt;
  // slot strobe bundle: {sel0, shift-FIFO ce, afifo1_wr_en, afifo0_wr_en}
  logic [3:0]        dly [PIPE_LAT];
  logic [3:0]        slot;

  logic phase;
  logic pause;
  logic in_win;
  logic issue;

  assign phase    = col[0];
  assign pause    = afifo0_full | afifo1_full;
  assign in_win   = (state == FILL) || (state == STREAM);
  assign in_ready = in_win && !phase && !pause;
  assign busy     = (state != IDLE);

  // Phase-1 slots are the interpolated half of a pixel pair and never wait.
  always_comb begin
    issue = 1'b0;
    if (in_win)
      issue = phase || (in_valid && !pause);
    else if (state == FLUSH)
      issue = phase || !pause;
  end

  assign slot = issue ? {phase, 1'b1, (row >= ROW_WR), (row >= ROW_WR) && (row <= ROW_FLUSH)}
                      : 4'b0000;

  assign sel0         = dly[PIPE_LAT-1][3];
  assign sfifo0_ce    = dly[PIPE_LAT-1][2];
  assign sfifo1_ce    = dly[PIPE_LAT-1][2];
  assign afifo1_wr_en = dly[PIPE_LAT-1][1];
  assign afifo0_wr_en = dly[PIPE_LAT-1][0];

  always_ff @(posedge sclk) begin
    if (rst) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      rst_cnt    <= '0;
      drain_cnt  <= '0;
      afifo_rst  <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < PIPE_LAT; i++) dly[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      dly[0]     <= slot;
      for (int i = 1; i < PIPE_LAT; i++) dly[i] <= dly[i-1];

      case (state)
        IDLE: begin
          if (start) begin
            state     <= RST_FIFO;
            afifo_rst <= 1'b1;
            rst_cnt   <= RCNT_W'(RST_CYCLES - 1);
            col       <= '0;
            row       <= '0;
          end
        end
        RST_FIFO: begin
          if (afifo_rst) begin
            if (rst_cnt == '0) afifo_rst <= 1'b0;
            else               rst_cnt   <= rst_cnt - RCNT_W'(1);
          end else if (!afifo0_wr_rst_busy && !afifo1_wr_rst_busy) begin
            state <= FILL;
          end
        end
        FILL, STREAM, FLUSH: begin
          if (issue) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + ROW_W'(1);
              if (row == ROW_LAST) begin
                state     <= DONE;
                drain_cnt <= DCNT_W'(PIPE_LAT - 1);
              end else if (row == ROW_PRE) begin
                state <= FLUSH;
              end else if (row == '0) begin
                state <= STREAM;
              end
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        DONE: begin
          if (drain_cnt == '0) begin
            frame_done <= 1'b1;
            state      <= IDLE;
          end else begin
            drain_cnt <= drain_cnt - DCNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INTERP_OVF_DETECT_EN
  // Flags a write that lands while its FIFO already reports full.
  always_ff @(posedge sclk) begin
    if (rst)
      ovf_err <= 1'b0;
    else if ((state == IDLE) && start)
      ovf_err <= 1'b0;
    else if ((afifo0_wr_en && afifo0_full) || (afifo1_wr_en && afifo1_full))
      ovf_err <= 1'b1;
  end
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_interp_wr_ctrl.sv
// Self-checking bench for interp_wr_ctrl at IMG_WIDTH=4, IMG_HEIGHT=3, PIPE_LAT=2.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_interp_wr_ctrl;

  logic sclk = 1'b0;
  logic rst, start, in_valid, in_ready;
  logic afifo0_full, afifo1_full, afifo0_wr_rst_busy, afifo1_wr_rst_busy;
  logic sel0, sfifo0_ce, sfifo1_ce, afifo0_wr_en, afifo1_wr_en;
  logic afifo_rst, busy, frame_done, ovf_err;

  interp_wr_ctrl #(
    .IMG_WIDTH (4),
    .IMG_HEIGHT(3),
    .PIPE_LAT  (2),
    .RST_CYCLES(4)
  ) dut (
    .sclk              (sclk),
    .rst               (rst),
    .start             (start),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .afifo0_full       (afifo0_full),
    .afifo1_full       (afifo1_full),
    .afifo0_wr_rst_busy(afifo0_wr_rst_busy),
    .afifo1_wr_rst_busy(afifo1_wr_rst_busy),
    .sel0              (sel0),
    .sfifo0_ce         (sfifo0_ce),
    .sfifo1_ce         (sfifo1_ce),
    .afifo0_wr_en      (afifo0_wr_en),
    .afifo1_wr_en      (afifo1_wr_en),
    .afifo_rst         (afifo_rst),
    .busy              (busy),
    .frame_done        (frame_done),
    .ovf_err           (ovf_err)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic       start;
    logic [1:0] rbusy;
    logic [3:0] exp;   // {afifo_rst, busy, in_ready, sfifo0_ce}
  } vec_t;

  vec_t vecs [9];

  int checks = 0, errors = 0;
  int ce_cnt = 0, wr0_cnt = 0, wr1_cnt = 0, acc_cnt = 0, fd_cnt = 0;
  int ce_base = 0, wr0_base = 0, wr1_base = 0, acc_base = 0, fd_base = 0;
  logic exp_sel = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge sclk);
    #1;
  endtask

  task automatic sample();
    @(negedge sclk);
    if (in_valid && in_ready) acc_cnt++;
    if (frame_done)   fd_cnt++;
    if (afifo0_wr_en) wr0_cnt++;
    if (afifo1_wr_en) wr1_cnt++;
    if (sfifo0_ce) begin
      ce_cnt++;
      check("sel0_alternate", sel0, exp_sel);
      check("sfifo1_ce_pair", sfifo1_ce, 1);
      exp_sel = ~exp_sel;
    end
  endtask

  function automatic logic [9:0] all_outs();
    return {in_ready, sel0, sfifo0_ce, sfifo1_ce, afifo0_wr_en, afifo1_wr_en,
            afifo_rst, busy, frame_done, ovf_err};
  endfunction

  task automatic set_bases();
    ce_base = ce_cnt; wr0_base = wr0_cnt; wr1_base = wr1_cnt;
    acc_base = acc_cnt; fd_base = fd_cnt;
    exp_sel = 1'b0;
  endtask

  task automatic do_start();
    bit filled = 0;
    next_cycle(); start = 1; in_valid = 0; sample();
    set_bases();
    next_cycle(); start = 0; sample();
    for (int i = 0; i < 50 && !filled; i++) begin
      next_cycle(); sample();
      if (in_ready) filled = 1;
    end
    if (!filled) check("start_reaches_fill", 0, 1);
  endtask

  task automatic check_totals(input string tag);
    check({tag, "_slots"},       ce_cnt  - ce_base,  40);
    check({tag, "_afifo1_wr"},   wr1_cnt - wr1_base, 24);
    check({tag, "_afifo0_wr"},   wr0_cnt - wr0_base, 16);
    check({tag, "_accepts"},     acc_cnt - acc_base, 12);
    check({tag, "_frame_done"},  fd_cnt  - fd_base,  1);
    next_cycle(); sample();
    check({tag, "_idle_after"},  busy, 0);
  endtask

  task automatic run_frame(input bit stall_en, input bit pause_en,
                           input bit abort_en, input bit ovf_en);
    int cyc = 0, stall_at = -100, pause_at = -100, post = 0, rel = 0;
    int ce_mark = 0, wr0_mark = 0, fd_mark;
    bit stall_done = 0, pause_done = 0, ovf_done = 0, finished = 0, aborted = 0;
    fd_mark = fd_cnt;
    while (!finished && !aborted && cyc < 300) begin
      next_cycle();
      rel = acc_cnt - acc_base;
      in_valid = 1; afifo0_full = 0; afifo1_full = 0;
      if (cyc - stall_at < 3) in_valid = 0;
      else if (stall_en && !stall_done && in_ready && rel == 6) begin
        stall_done = 1; stall_at = cyc; in_valid = 0;
      end
      if (cyc - pause_at < 10) afifo0_full = 1;
      else if (pause_en && !pause_done && in_ready && rel == 9) begin
        pause_done = 1; pause_at = cyc; afifo0_full = 1; wr0_mark = wr0_cnt;
      end
      if (ovf_en && !ovf_done && afifo1_wr_en) begin
        ovf_done = 1; afifo1_full = 1;
      end
      if (abort_en && rel == 12) begin
        post++;
        if (post == 4) begin rst = 1; aborted = 1; end
      end
      sample();
      if (cyc - stall_at < 3)     check("stall_hold_ready", in_ready, 1);
      if (cyc == stall_at + 1)    ce_mark = ce_cnt;
      if (cyc == stall_at + 4)    check("stall_no_strobes", ce_cnt - ce_mark, 0);
      if (cyc - pause_at < 10)    check("pause_ready_low", in_ready, 0);
      if (cyc == pause_at + 9)    check("pause_inflight_le2", int'((wr0_cnt - wr0_mark) <= 2), 1);
      if (fd_cnt != fd_mark)      finished = 1;
      cyc++;
    end
    if (stall_en && !stall_done) check("stall_triggered", 0, 1);
    if (pause_en && !pause_done) check("pause_triggered", 0, 1);
    if (aborted) begin
      next_cycle(); rst = 0; in_valid = 0; sample();
      check("abort_outputs_zero", all_outs(), 0);
    end else if (!finished) begin
      check("frame_timeout", 0, 1);
    end
    in_valid = 0; afifo0_full = 0; afifo1_full = 0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'b00, 4'b0000};
    vecs[1] = '{1'b0, 2'b11, 4'b1100};
    vecs[2] = '{1'b1, 2'b11, 4'b1100};
    vecs[3] = '{1'b0, 2'b11, 4'b1100};
    vecs[4] = '{1'b0, 2'b11, 4'b1100};
    vecs[5] = '{1'b0, 2'b11, 4'b0100};
    vecs[6] = '{1'b0, 2'b01, 4'b0100};
    vecs[7] = '{1'b0, 2'b00, 4'b0100};
    vecs[8] = '{1'b0, 2'b00, 4'b0110};

    rst = 1; start = 0; in_valid = 0;
    afifo0_full = 0; afifo1_full = 0; afifo0_wr_rst_busy = 0; afifo1_wr_rst_busy = 0;
    repeat (3) begin next_cycle(); sample(); end
    next_cycle(); rst = 0; sample();
    check("reset_outputs", all_outs(), 0);

    // frame 1: reset-FIFO handshake from the vector table
    for (int i = 0; i < 9; i++) begin
      next_cycle();
      start = vecs[i].start;
      {afifo0_wr_rst_busy, afifo1_wr_rst_busy} = vecs[i].rbusy;
      sample();
      check($sformatf("vec%0d_rst_busy_ready_ce", i),
            {afifo_rst, busy, in_ready, sfifo0_ce}, vecs[i].exp);
    end
    start = 0;
    exp_sel = 1'b0;

    // first accept to first strobe latency
    for (int i = 0; i < 4; i++) begin
      next_cycle(); in_valid = 1; sample();
      check($sformatf("lat%0d_in_ready", i), in_ready, (i % 2 == 0) ? 1 : 0);
      check($sformatf("lat%0d_sfifo0_ce", i), sfifo0_ce, (i >= 2) ? 1 : 0);
      check($sformatf("lat%0d_afifo1_wr_en", i), afifo1_wr_en, 0);
    end
    run_frame(1'b1, 1'b1, 1'b0, 1'b0);
    check_totals("frame1");
`ifndef INTERP_OVF_DETECT_EN
    check("frame1_ovf_err", ovf_err, 0);
`endif

    // frame 2: reset during FLUSH
    do_start();
    run_frame(1'b0, 1'b0, 1'b1, 1'b0);
    begin
      int fd_mark;
      fd_mark = fd_cnt;
      repeat (10) begin next_cycle(); sample(); end
      check("abort_no_frame_done", fd_cnt - fd_mark, 0);
      check("abort_idle", busy, 0);
    end

    // frame 3: clean frame after the abort
    do_start();
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);
    check_totals("frame3");
`ifdef INTERP_OVF_DETECT_EN
    check("ovf_sticky", ovf_err, 1);
    do_start();
    check("ovf_cleared_by_start", ovf_err, 0);
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);
`else
    check("frame3_ovf_err", ovf_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
